// File: rtl/simple_pkg.sv
// Shared defaults and helpers for the 'simple' netlist response collector.
package simple_pkg;

   localparam int unsigned WORD_W_DEF     = 8;
   localparam int unsigned FIFO_DEPTH_DEF = 4;
   localparam logic [7:0]  MISR_POLY_DEF  = 8'hB8;
   localparam logic [7:0]  MISR_SEED_DEF  = 8'h00;

   // Ceiling log2; used for pointer and bit-counter widths.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(v)) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/simple_word_fifo.sv
// Synchronous first-word-fall-through FIFO holding packed response words.
module simple_word_fifo
   import simple_pkg::*;
#(
   parameter int unsigned W     = WORD_W_DEF,
   parameter int unsigned DEPTH = FIFO_DEPTH_DEF
) (
   input  logic         iccad_clk,
   input  logic         iccad_rst,
   input  logic         clr,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] pop_data,
   output logic         full,
   output logic         empty
);

   localparam int unsigned AW = clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [W-1:0]  mem_d [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic          pop_ok;
   logic          push_ok;

   assign empty    = (wr_ptr_q == rd_ptr_q);
   assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign pop_data = mem_q[rd_ptr_q[AW-1:0]];
   assign pop_ok   = pop & ~empty;
   // A pop on the same edge frees the slot the push is about to use.
   assign push_ok  = push & (~full | pop_ok);

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (clr) begin
         for (int i = 0; i < int'(DEPTH); i++) mem_d[i] = '0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (push_ok) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_data;
            wr_ptr_d                = wr_ptr_q + PW'(1);
         end
         if (pop_ok) rd_ptr_d = rd_ptr_q + PW'(1);
      end
   end

   always_ff @(posedge iccad_clk or posedge iccad_rst) begin
      if (iccad_rst) begin
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

endmodule

// File: rtl/simple_resp_collector.sv
// Samples the 'simple' netlist output, packs bits MSB-first into words, buffers them,
// and keeps a MISR signature of every sampled bit.
module simple_resp_collector
   import simple_pkg::*;
#(
   parameter int unsigned       WORD_W     = WORD_W_DEF,
   parameter int unsigned       FIFO_DEPTH = FIFO_DEPTH_DEF,
   parameter logic [WORD_W-1:0] MISR_POLY  = WORD_W'(MISR_POLY_DEF),
   parameter logic [WORD_W-1:0] MISR_SEED  = WORD_W'(MISR_SEED_DEF)
) (
   input  logic              iccad_clk,
   input  logic              iccad_rst,
   input  logic              clr,
   input  logic              en,
   input  logic              out_in,
   output logic [WORD_W-1:0] word_data,
   output logic              word_valid,
   input  logic              word_ready,
   output logic              overflow,
   output logic [WORD_W-1:0] signature
);

   localparam int unsigned     CNT_W    = clog2(WORD_W);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

   logic [WORD_W-2:0] shreg_q, shreg_d;
   logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [WORD_W-1:0] sig_q, sig_d;
   logic              overflow_q, overflow_d;

   logic [WORD_W-1:0] push_word;
   logic [WORD_W-1:0] misr_next;
   logic              word_done;
   logic              push;
   logic              pop_fire;
   logic              fifo_full;
   logic              fifo_empty;

   assign push_word  = {shreg_q, out_in};
   assign word_done  = en & (bit_cnt_q == LAST_BIT);
   assign push       = word_done & ~clr;
   assign word_valid = ~fifo_empty;
   assign pop_fire   = word_valid & word_ready & ~clr;
   assign misr_next  = (sig_q << 1) ^ (sig_q[WORD_W-1] ? MISR_POLY : '0) ^ WORD_W'(out_in);
   assign signature  = sig_q;
   assign overflow   = overflow_q;

   always_comb begin
      shreg_d    = shreg_q;
      bit_cnt_d  = bit_cnt_q;
      sig_d      = sig_q;
      overflow_d = overflow_q;
      if (clr) begin
         shreg_d    = '0;
         bit_cnt_d  = '0;
         sig_d      = MISR_SEED;
         overflow_d = 1'b0;
      end else begin
         if (en) begin
            shreg_d   = push_word[WORD_W-2:0];
            bit_cnt_d = word_done ? '0 : bit_cnt_q + CNT_W'(1);
            sig_d     = misr_next;
         end
         // Completed word with nowhere to go is lost; remember it until cleared.
         if (push && fifo_full && !pop_fire) overflow_d = 1'b1;
      end
   end

   always_ff @(posedge iccad_clk or posedge iccad_rst) begin
      if (iccad_rst) begin
         shreg_q    <= '0;
         bit_cnt_q  <= '0;
         sig_q      <= MISR_SEED;
         overflow_q <= 1'b0;
      end else begin
         shreg_q    <= shreg_d;
         bit_cnt_q  <= bit_cnt_d;
         sig_q      <= sig_d;
         overflow_q <= overflow_d;
      end
   end

   simple_word_fifo #(
      .W     (WORD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .iccad_clk (iccad_clk),
      .iccad_rst (iccad_rst),
      .clr       (clr),
      .push      (push),
      .push_data (push_word),
      .pop       (word_ready),
      .pop_data  (word_data),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

endmodule

// File: tb/tb_simple_resp_collector.sv
// Directed bench for simple_resp_collector (WORD_W=8, FIFO_DEPTH=4, POLY=B8, SEED=00).
module tb_simple_resp_collector;

   logic       iccad_clk;
   logic       iccad_rst;
   logic       clr;
   logic       en;
   logic       out_in;
   logic [7:0] word_data;
   logic       word_valid;
   logic       word_ready;
   logic       overflow;
   logic [7:0] signature;

   int n_vec = 0;
   int n_mis = 0;
   logic [7:0] exp_sig;

   simple_resp_collector dut (
      .iccad_clk  (iccad_clk),
      .iccad_rst  (iccad_rst),
      .clr        (clr),
      .en         (en),
      .out_in     (out_in),
      .word_data  (word_data),
      .word_valid (word_valid),
      .word_ready (word_ready),
      .overflow   (overflow),
      .signature  (signature)
   );

   initial iccad_clk = 1'b0;
   always #5 iccad_clk = ~iccad_clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Independent reference of one signature step.
   function automatic logic [7:0] misr_ref(input logic [7:0] s, input logic b);
      logic [7:0] t;
      t = {s[6:0], 1'b0};
      if (s[7]) t = t ^ 8'hB8;
      return t ^ {7'd0, b};
   endfunction

   task automatic tick();
      @(posedge iccad_clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      en     = 1'b1;
      out_in = b;
      tick();
      en     = 1'b0;
   endtask

   task automatic send_word(input logic [7:0] w);
      for (int i = 7; i >= 0; i--) send_bit(w[i]);
   endtask

   task automatic pulse_clr();
      clr = 1'b1;
      tick();
      clr = 1'b0;
   endtask

   initial begin
      logic [7:0] w;
      iccad_rst  = 1'b1;
      clr        = 1'b0;
      en         = 1'b0;
      out_in     = 1'b0;
      word_ready = 1'b0;
      #12;
      chk("rst_valid", 32'(word_valid), 32'd0);
      chk("rst_data",  32'(word_data),  32'h00);
      chk("rst_sig",   32'(signature),  32'h00);
      chk("rst_ovf",   32'(overflow),   32'd0);
      iccad_rst = 1'b0;

      // Test 1: 1,0,1,1,0,0,1,0 -> B2
      word_ready = 1'b1;
      w = 8'hB2;
      for (int i = 7; i >= 1; i--) send_bit(w[i]);
      chk("t1_valid_early", 32'(word_valid), 32'd0);
      send_bit(w[0]);
      chk("t1_valid", 32'(word_valid), 32'd1);
      chk("t1_data",  32'(word_data),  32'hB2);
      chk("t1_sig",   32'(signature),  32'hB2);

      // Test 2: 9th bit pops B2, signature DD, partial word continues
      send_bit(1'b1);
      chk("t2_sig",   32'(signature),  32'hDD);
      chk("t2_valid", 32'(word_valid), 32'd0);
      w = 8'hAA;
      for (int i = 6; i >= 0; i--) send_bit(w[i]);
      chk("t2_valid_word", 32'(word_valid), 32'd1);
      chk("t2_data",       32'(word_data),  32'hAA);
      tick();
      word_ready = 1'b0;
      chk("t2_drained", 32'(word_valid), 32'd0);

      // Test 3: overflow on fifth word with ready low, then drain
      pulse_clr();
      chk("t3_clr_sig", 32'(signature), 32'h00);
      for (int k = 0; k < 4; k++) send_word(8'hA1 + 8'(k));
      chk("t3_full_ovf",  32'(overflow),  32'd0);
      chk("t3_full_data", 32'(word_data), 32'hA1);
      send_word(8'hA5);
      chk("t3_ovf",       32'(overflow),  32'd1);
      chk("t3_head_hold", 32'(word_data), 32'hA1);
      word_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         chk("t3_pop_valid", 32'(word_valid), 32'd1);
         chk("t3_pop_data",  32'(word_data),  32'(8'hA1 + 8'(k)));
         tick();
      end
      word_ready = 1'b0;
      chk("t3_empty",      32'(word_valid), 32'd0);
      chk("t3_ovf_sticky", 32'(overflow),   32'd1);

      // Test 5: async reset mid-word clears immediately
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      #2 iccad_rst = 1'b1;
      #1;
      chk("t5_rst_ovf",  32'(overflow),  32'd0);
      chk("t5_rst_sig",  32'(signature), 32'h00);
      chk("t5_rst_data", 32'(word_data), 32'h00);
      #1 iccad_rst = 1'b0;
      send_word(8'hFF);
      chk("t5_valid", 32'(word_valid), 32'd1);
      chk("t5_data",  32'(word_data),  32'hFF);
      chk("t5_sig",   32'(signature),  32'hFF);
      word_ready = 1'b1;
      tick();
      word_ready = 1'b0;
      chk("t5_drained", 32'(word_valid), 32'd0);

      // Test 4: full FIFO with pop on the edge a fifth word completes
      pulse_clr();
      for (int k = 0; k < 4; k++) send_word(8'h11 * 8'(k + 1));
      w = 8'h55;
      for (int i = 7; i >= 1; i--) send_bit(w[i]);
      word_ready = 1'b1;
      send_bit(w[0]);
      word_ready = 1'b0;
      chk("t4_ovf",  32'(overflow),  32'd0);
      chk("t4_head", 32'(word_data), 32'h22);
      word_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         chk("t4_pop_data", 32'(word_data), 32'(8'h11 * 8'(k + 2)));
         tick();
      end
      word_ready = 1'b0;
      chk("t4_empty", 32'(word_valid), 32'd0);

      // Test 6: en toggling, head held under ready=0, then clr mid-stream
      pulse_clr();
      exp_sig = 8'h00;
      w = 8'hC3;
      for (int i = 7; i >= 0; i--) begin
         send_bit(w[i]);
         exp_sig = misr_ref(exp_sig, w[i]);
         out_in = ~w[i];
         tick();
      end
      chk("t6_valid", 32'(word_valid), 32'd1);
      chk("t6_data",  32'(word_data),  32'hC3);
      chk("t6_sig",   32'(signature),  32'(exp_sig));
      w = 8'h5A;
      for (int i = 7; i >= 4; i--) begin
         send_bit(w[i]);
         exp_sig = misr_ref(exp_sig, w[i]);
         tick();
         chk("t6_hold", 32'(word_data), 32'hC3);
      end
      chk("t6_sig_partial", 32'(signature), 32'(exp_sig));
      clr        = 1'b1;
      en         = 1'b1;
      out_in     = 1'b1;
      word_ready = 1'b1;
      tick();
      clr        = 1'b0;
      en         = 1'b0;
      word_ready = 1'b0;
      chk("t6_clr_valid", 32'(word_valid), 32'd0);
      chk("t6_clr_data",  32'(word_data),  32'h00);
      chk("t6_clr_sig",   32'(signature),  32'h00);
      chk("t6_clr_ovf",   32'(overflow),   32'd0);
      exp_sig = 8'h00;
      w = 8'h3C;
      for (int i = 7; i >= 0; i--) exp_sig = misr_ref(exp_sig, w[i]);
      send_word(w);
      chk("t6_new_valid", 32'(word_valid), 32'd1);
      chk("t6_new_data",  32'(word_data),  32'h3C);
      chk("t6_new_sig",   32'(signature),  32'(exp_sig));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
